// File: rtl/rename_reg_file.sv
// Architectural register file with rename (dependency) table, commit forwarding and busy counter.
// Optional branch checkpoints of the dependency table are enabled by defining REGFILE_CKPT_EN.
module rename_reg_file #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned ROB_W = 4,
  parameter int unsigned NRP   = 2,
  parameter int unsigned NCKPT = 4,
  localparam int unsigned RW   = $clog2(NREG),
  localparam int unsigned CK_W = $clog2(NCKPT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [NRP*RW-1:0]     rd_id,
  output logic [NRP-1:0]        rd_has_dep,
  output logic [NRP*ROB_W-1:0]  rd_dep,
  output logic [NRP*XLEN-1:0]   rd_val,
  output logic [NRP*ROB_W-1:0]  rob_qid,
  input  logic [NRP-1:0]        rob_qready,
  input  logic [NRP*XLEN-1:0]   rob_qval,
  input  logic                  disp_en,
  input  logic [RW-1:0]         disp_reg,
  input  logic [ROB_W-1:0]      disp_rob,
  input  logic                  cmt_en,
  input  logic [RW-1:0]         cmt_reg,
  input  logic [ROB_W-1:0]      cmt_rob,
  input  logic [XLEN-1:0]       cmt_val,
  input  logic                  flush,
  input  logic                  ckpt_save,
  input  logic [CK_W-1:0]       ckpt_sid,
  input  logic                  ckpt_rst,
  input  logic [CK_W-1:0]       ckpt_rid,
  output logic [RW:0]           busy_cnt
);

  logic [XLEN-1:0]  regs [NREG];
  logic [NREG-1:0]  has_dep;
  logic [ROB_W-1:0] dep [NREG];

  logic [NREG-1:0]  has_dep_nxt;
  logic [ROB_W-1:0] dep_nxt [NREG];
  logic [RW:0]      busy_nxt;

  logic disp_ok;
  logic cmt_wr;
  logic clear_all;

  assign disp_ok = disp_en && (disp_reg != '0);
  assign cmt_wr  = cmt_en && (cmt_reg != '0);

`ifdef REGFILE_CKPT_EN
  logic [NREG-1:0]  ck_has [NCKPT];
  logic [ROB_W-1:0] ck_dep [NCKPT][NREG];

  assign clear_all = flush;
`else
  logic unused_ckpt;

  // Without checkpoint storage a restore can only fall back to a full clear.
  assign clear_all   = flush || ckpt_rst;
  assign unused_ckpt = ^{ckpt_save, ckpt_sid, ckpt_rid};
`endif

  // Operand lookup: dispatch bypass, commit forward, ROB value, then architectural value.
  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [RW-1:0]    r;
    logic             hit;
    logic [ROB_W-1:0] tag;
    logic             has_c;
    logic [XLEN-1:0]  val_c;

    assign r   = rd_id[p*RW +: RW];
    assign hit = disp_ok && (disp_reg == r);
    assign tag = hit ? disp_rob : dep[r];

    always_comb begin
      has_c = 1'b0;
      val_c = regs[r];
      if (r == '0) begin
        val_c = '0;
      end else if (cmt_en && (cmt_reg == r) && (cmt_rob == tag) && !hit) begin
        val_c = cmt_val;
      end else if (hit || has_dep[r]) begin
        val_c = rob_qval[p*XLEN +: XLEN];
        has_c = ~rob_qready[p];
      end
    end

    assign rd_has_dep[p]              = has_c;
    assign rd_val[p*XLEN +: XLEN]     = val_c;
    assign rd_dep[p*ROB_W +: ROB_W]   = tag;
    assign rob_qid[p*ROB_W +: ROB_W]  = tag;
  end

  // Next dependency table: flush > restore > commit-clear then dispatch.
  always_comb begin
    has_dep_nxt = has_dep;
    for (int i = 0; i < NREG; i++) dep_nxt[i] = dep[i];
    if (clear_all) begin
      has_dep_nxt = '0;
      for (int i = 0; i < NREG; i++) dep_nxt[i] = '0;
    end
`ifdef REGFILE_CKPT_EN
    else if (ckpt_rst) begin
      has_dep_nxt = ck_has[ckpt_rid];
      for (int i = 0; i < NREG; i++) dep_nxt[i] = ck_dep[ckpt_rid][i];
      if (cmt_en && (ck_dep[ckpt_rid][cmt_reg] == cmt_rob)) has_dep_nxt[cmt_reg] = 1'b0;
    end
`endif
    else begin
      if (cmt_en && (dep[cmt_reg] == cmt_rob)) has_dep_nxt[cmt_reg] = 1'b0;
      if (disp_ok) begin
        has_dep_nxt[disp_reg] = 1'b1;
        dep_nxt[disp_reg]     = disp_rob;
      end
    end
  end

  always_comb begin
    busy_nxt = '0;
    for (int i = 0; i < NREG; i++) busy_nxt = busy_nxt + (RW+1)'(has_dep_nxt[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        dep[i]  <= '0;
      end
      has_dep  <= '0;
      busy_cnt <= '0;
    end else if (rdy) begin
      if (cmt_wr) regs[cmt_reg] <= cmt_val;
      has_dep  <= has_dep_nxt;
      for (int i = 0; i < NREG; i++) dep[i] <= dep_nxt[i];
      busy_cnt <= busy_nxt;
    end
  end

`ifdef REGFILE_CKPT_EN
  // Retire committed tags from every snapshot; a save captures the post-dispatch table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCKPT; k++) begin
        ck_has[k] <= '0;
        for (int i = 0; i < NREG; i++) ck_dep[k][i] <= '0;
      end
    end else if (rdy) begin
      for (int k = 0; k < NCKPT; k++) begin
        if (cmt_en && (ck_dep[k][cmt_reg] == cmt_rob)) ck_has[k][cmt_reg] <= 1'b0;
      end
      if (ckpt_save && !flush && !ckpt_rst) begin
        ck_has[ckpt_sid] <= has_dep_nxt;
        for (int i = 0; i < NREG; i++) ck_dep[ckpt_sid][i] <= dep_nxt[i];
      end
    end
  end
`endif

endmodule
